// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch/flag stage: FSM states, branch
// conditions, compare results, opcodes and the branch predicate.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_EQ     = 2'b01;
  localparam logic [1:0] BR_GT     = 2'b10;
  localparam logic [1:0] BR_LT     = 2'b11;

  localparam logic [1:0] CMP_EQ   = 2'b10;
  localparam logic [1:0] CMP_GT   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b00;
  localparam logic [1:0] CMP_NONE = 2'b11;

  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_CMP   = 4'd7;
  localparam logic [3:0] OP_SHIFT = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // CMP_NONE matches no conditional case, so those fall through.
  function automatic logic br_taken(
    input logic [1:0] cond,
    input logic [1:0] cmp
  );
    logic t;
    t = 1'b0;
    unique case (cond)
      BR_ALWAYS: t = 1'b1;
      BR_EQ:     t = (cmp == CMP_EQ);
      BR_GT:     t = (cmp == CMP_GT);
      BR_LT:     t = (cmp == CMP_LT);
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_flag_ctrl_if.sv
// Decode/ALU side bundle into the fetch/flag stage and its
// registered PC, flag and status outputs.
interface fetch_flag_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
);
  logic             start;
  logic [3:0]       alu_op;
  logic             carry_out;
  logic [1:0]       compare_flag;
  logic             branch;
  logic [1:0]       branch_cond;
  logic [LUT_W-1:0] branch_idx;
  logic [PC_W-1:0]  prog_ctr;
  logic             carry_flag;
  logic [1:0]       cmp_flag;
  logic             running;
  logic             done;

  modport master (
    output start, alu_op, carry_out, compare_flag,
    output branch, branch_cond, branch_idx,
    input  prog_ctr, carry_flag, cmp_flag, running, done
  );

  modport slave (
    input  start, alu_op, carry_out, compare_flag,
    input  branch, branch_cond, branch_idx,
    output prog_ctr, carry_flag, cmp_flag, running, done
  );
endinterface

// File: rtl/branch_lut.sv
// Absolute branch targets for the current program image.
// Unlisted indices resolve to address 0.
module branch_lut #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic [LUT_W-1:0] idx,
  output logic [PC_W-1:0]  target
);

  always_comb begin
    target = '0;
    case (idx)
      LUT_W'(1): target = PC_W'(1023);
      LUT_W'(3): target = PC_W'(40);
      LUT_W'(4): target = PC_W'(17);
      LUT_W'(5): target = PC_W'(100);
      LUT_W'(6): target = PC_W'(512);
      default:   target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_flag_ctrl.sv
// Fetch/flag stage: run/halt FSM, PC sequencing through the branch
// LUT, and architectural carry/compare flag registers.
module fetch_flag_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic Clk,
  input  logic Reset_n,
  fetch_flag_ctrl_if.slave bus
);

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] lut_tgt;
  logic            carry_q;
  logic [1:0]      cmp_q;
  logic            run_q;
  logic            done_q;
  logic            take;
  logic            carry_op;

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_lut (
    .idx    (bus.branch_idx),
    .target (lut_tgt)
  );

  // Conditions see the registered compare, never this cycle's result.
  assign take = bus.branch & br_taken(bus.branch_cond, cmp_q);

  assign carry_op = bus.alu_op inside {OP_ADD, OP_SUB, OP_ADDI, OP_SHIFT};

  assign next_pc = take ? lut_tgt : pc_q + PC_W'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      pc_q    <= '0;
      carry_q <= 1'b0;
      cmp_q   <= CMP_NONE;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= RUN;
            pc_q    <= '0;
            carry_q <= 1'b0;
            cmp_q   <= CMP_NONE;
            run_q   <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.alu_op == OP_HALT) begin
            state  <= DONE;
            run_q  <= 1'b0;
            done_q <= 1'b1;
          end else begin
            pc_q <= next_pc;
            if (carry_op)
              carry_q <= bus.carry_out;
            if (bus.alu_op == OP_CMP)
              cmp_q <= bus.compare_flag;
          end
        end
        default: begin
          state  <= IDLE;
          run_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_ctr   = pc_q;
  assign bus.carry_flag = carry_q;
  assign bus.cmp_flag   = cmp_q;
  assign bus.running    = run_q;
  assign bus.done       = done_q;

endmodule
